// File: rtl/glyph_fetch.sv
// glyph_fetch: three-register pixel pipeline from VGA counts to RGB 3-3-2 via tile map, glyph ROM and palette.
// Optional blinking cursor overlay is compiled in when CURSOR_OVERLAY_EN is defined.
module glyph_fetch #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        bright_in,
  input  logic        hSync_in,
  input  logic        vSync_in,
  output logic [10:0] tile_addr,
  input  logic [7:0]  tile_data,
  output logic [8:0]  glyph_addr,
  input  logic [15:0] glyph_data,
`ifdef CURSOR_OVERLAY_EN
  input  logic [5:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic        cursor_on,
`endif
  output logic [7:0]  rgb,
  output logic        bright,
  output logic        hSync,
  output logic        vSync
);

  localparam int             LATENCY   = 3;
  localparam logic [9:0]     H_ACTIVE  = 10'(COLS * 16);
  localparam logic [9:0]     V_ACTIVE  = 10'(ROWS * 16);
  localparam logic [10:0]    COLS_W    = 11'(COLS);
  localparam logic [7:0]     BLACK     = 8'h00;
  // {bright, hSync, vSync} idle value: syncs are active-low
  localparam logic [2:0]     SYNC_IDLE = 3'b011;
  localparam logic [3*LATENCY-1:0] SYNC_RST = {LATENCY{SYNC_IDLE}};

  function automatic logic [7:0] pal_color(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'h00;
      3'd1:    c = 8'h03;
      3'd2:    c = 8'h1C;
      3'd3:    c = 8'h1F;
      3'd4:    c = 8'hE0;
      3'd5:    c = 8'hE3;
      3'd6:    c = 8'hFC;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  logic [5:0]  h_tile;
  logic [4:0]  v_tile;
  logic        valid0_d;

  // Stage 0 state
  logic [10:0] tile_addr_q, tile_addr_d;
  logic [3:0]  col0_q, col0_d;
  logic [3:0]  row0_q, row0_d;
  logic        valid0_q;

  // Stage 1 state
  logic [8:0]  glyph_addr_q, glyph_addr_d;
  logic [2:0]  pal1_q, pal1_d;
  logic [3:0]  col1_q, col1_d;
  logic        valid1_q, valid1_d;

  // Stage 2 state
  logic [7:0]  rgb_q, rgb_d;
  logic        pix;
  logic [7:0]  rgb_base;

  logic [3*LATENCY-1:0] sync_q, sync_d;

  assign h_tile = hCount[9:4];
  assign v_tile = vCount[8:4];

  always_comb begin
    valid0_d    = bright_in & (hCount < H_ACTIVE) & (vCount < V_ACTIVE);
    // Blanked positions read address 0 so the tile map never sees an out-of-range address
    tile_addr_d = valid0_d ? (11'(v_tile) * COLS_W + 11'(h_tile)) : 11'd0;
    col0_d      = hCount[3:0];
    row0_d      = vCount[3:0];
  end

  always_comb begin
    glyph_addr_d = {tile_data[4:0], row0_q};
    pal1_d       = tile_data[7:5];
    col1_d       = col0_q;
    valid1_d     = valid0_q;
  end

  always_comb begin
    sync_d = {sync_q[3*LATENCY-4:0], bright_in, hSync_in, vSync_in};
  end

`ifdef CURSOR_OVERLAY_EN
  logic [5:0] frame_cnt_q, frame_cnt_d;
  logic       vs_prev_q, vs_prev_d;
  logic       hit0_q, hit0_d;
  logic       hit1_q, hit1_d;

  always_comb begin
    vs_prev_d   = vSync_in;
    frame_cnt_d = frame_cnt_q;
    if (vs_prev_q && !vSync_in)
      frame_cnt_d = frame_cnt_q + 6'd1;
    // frame_cnt[5] is the blink phase: 32 frames on, 32 off
    hit0_d = cursor_on & frame_cnt_q[5] & valid0_d &
             (h_tile == cursor_col) & (v_tile == cursor_row);
    hit1_d = hit0_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= 6'd0;
      vs_prev_q   <= 1'b1;
      hit0_q      <= 1'b0;
      hit1_q      <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      vs_prev_q   <= vs_prev_d;
      hit0_q      <= hit0_d;
      hit1_q      <= hit1_d;
    end
  end
`endif

  always_comb begin
    pix      = glyph_data[4'd15 - col1_q];
    rgb_base = (valid1_q && pix) ? pal_color(pal1_q) : BLACK;
    rgb_d    = rgb_base;
`ifdef CURSOR_OVERLAY_EN
    if (hit1_q)
      rgb_d = ~rgb_base;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_addr_q  <= 11'd0;
      col0_q       <= 4'd0;
      row0_q       <= 4'd0;
      valid0_q     <= 1'b0;
      glyph_addr_q <= 9'd0;
      pal1_q       <= 3'd0;
      col1_q       <= 4'd0;
      valid1_q     <= 1'b0;
      rgb_q        <= BLACK;
      sync_q       <= SYNC_RST;
    end else begin
      tile_addr_q  <= tile_addr_d;
      col0_q       <= col0_d;
      row0_q       <= row0_d;
      valid0_q     <= valid0_d;
      glyph_addr_q <= glyph_addr_d;
      pal1_q       <= pal1_d;
      col1_q       <= col1_d;
      valid1_q     <= valid1_d;
      rgb_q        <= rgb_d;
      sync_q       <= sync_d;
    end
  end

  assign tile_addr  = tile_addr_q;
  assign glyph_addr = glyph_addr_q;
  assign rgb        = rgb_q;
  assign bright     = sync_q[3*LATENCY-1];
  assign hSync      = sync_q[3*LATENCY-2];
  assign vSync      = sync_q[3*LATENCY-3];

endmodule

// File: tb/tb_glyph_fetch.sv
// Directed bench for glyph_fetch; memories are registered-address models read from the DUT address outputs.
// Define CURSOR_OVERLAY_EN to also exercise the cursor overlay.
module tb_glyph_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hCount, vCount;
  logic        bright_in, hSync_in, vSync_in;
  logic [10:0] tile_addr;
  logic [7:0]  tile_data;
  logic [8:0]  glyph_addr;
  logic [15:0] glyph_data;
  logic [7:0]  rgb;
  logic        bright, hSync, vSync;
`ifdef CURSOR_OVERLAY_EN
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        cursor_on;
`endif

  logic [7:0]  tile_mem  [1200];
  logic [15:0] glyph_rom [512];
  logic [7:0]  pal_tab   [8] = '{8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign tile_data  = (tile_addr < 11'd1200) ? tile_mem[tile_addr] : 8'h00;
  assign glyph_data = glyph_rom[glyph_addr];

  glyph_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .hCount     (hCount),
    .vCount     (vCount),
    .bright_in  (bright_in),
    .hSync_in   (hSync_in),
    .vSync_in   (vSync_in),
    .tile_addr  (tile_addr),
    .tile_data  (tile_data),
    .glyph_addr (glyph_addr),
    .glyph_data (glyph_data),
`ifdef CURSOR_OVERLAY_EN
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .cursor_on  (cursor_on),
`endif
    .rgb        (rgb),
    .bright     (bright),
    .hSync      (hSync),
    .vSync      (vSync)
  );

  task automatic drive(input int h, input int v, input bit b, input bit hs, input bit vs);
    hCount    = 10'(h);
    vCount    = 10'(v);
    bright_in = b;
    hSync_in  = hs;
    vSync_in  = vs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_rgb(input int h, input int v, input bit b);
    logic [7:0]  t;
    logic [15:0] g;
    if (!b || h >= 640 || v >= 480) return 8'h00;
    t = tile_mem[(v / 16) * 40 + h / 16];
    g = glyph_rom[int'(t[4:0]) * 16 + v % 16];
    if (!g[15 - h % 16]) return 8'h00;
    return pal_tab[t[7:5]];
  endfunction

  task automatic test_reset();
    #2;
    n_cmp++; if (rgb !== 8'h00) begin n_bad++; $display("FAIL reset_rgb: got %h want 00", rgb); end
    n_cmp++; if (bright !== 1'b0) begin n_bad++; $display("FAIL reset_bright: got %b want 0", bright); end
    n_cmp++; if (hSync !== 1'b1 || vSync !== 1'b1) begin n_bad++; $display("FAIL reset_sync: got %b%b want 11", hSync, vSync); end
    n_cmp++; if (tile_addr !== 11'd0 || glyph_addr !== 9'd0) begin n_bad++; $display("FAIL reset_addr: got %0d/%0d want 0/0", tile_addr, glyph_addr); end
    @(posedge clk); #1 reset = 1'b0;
    drive(32, 18, 1, 0, 0);
    tick(); tick(); tick();
    n_cmp++; if (rgb !== 8'hE3 || hSync !== 1'b0) begin n_bad++; $display("FAIL pre_reset_pixel: got rgb %h hs %b want E3 0", rgb, hSync); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (rgb !== 8'h00 || bright !== 1'b0 || hSync !== 1'b1 || vSync !== 1'b1) begin
      n_bad++; $display("FAIL midline_reset: got rgb %h b %b hs %b vs %b want 00 0 1 1", rgb, bright, hSync, vSync); end
    tick();
    n_cmp++; if (rgb !== 8'h00 || tile_addr !== 11'd0 || hSync !== 1'b1) begin
      n_bad++; $display("FAIL reset_held: got rgb %h addr %0d hs %b want 00 0 1", rgb, tile_addr, hSync); end
    reset = 1'b0;
    tick(); tick();
    n_cmp++; if (rgb !== 8'h00) begin n_bad++; $display("FAIL release_early: got %h want 00", rgb); end
    tick();
    n_cmp++; if (rgb !== 8'hE3) begin n_bad++; $display("FAIL release_first: got %h want E3", rgb); end
    $display("test_reset done, %0d compared", n_cmp);
  endtask

  task automatic test_addressing();
    drive(639, 479, 1, 1, 1);
    tick();
    n_cmp++; if (tile_addr !== 11'd1199) begin n_bad++; $display("FAIL addr_max: got %0d want 1199", tile_addr); end
    drive(16, 16, 1, 1, 1);
    tick();
    n_cmp++; if (tile_addr !== 11'd41) begin n_bad++; $display("FAIL addr_16_16: got %0d want 41", tile_addr); end
    n_cmp++; if (glyph_addr !== 9'd15) begin n_bad++; $display("FAIL glyph_addr_max_row: got %0d want 15", glyph_addr); end
    drive(100, 200, 1, 1, 1);
    tick();
    n_cmp++; if (tile_addr !== 11'd486) begin n_bad++; $display("FAIL addr_100_200: got %0d want 486", tile_addr); end
    $display("test_addressing done, %0d compared", n_cmp);
  endtask

  task automatic test_pixel();
    drive(32, 18, 1, 1, 1);
    tick();
    n_cmp++; if (tile_addr !== 11'd42) begin n_bad++; $display("FAIL pix_tile_addr: got %0d want 42", tile_addr); end
    drive(33, 18, 1, 1, 1);
    tick();
    n_cmp++; if (glyph_addr !== 9'd82) begin n_bad++; $display("FAIL pix_glyph_addr: got %0d want 82", glyph_addr); end
    tick();
    n_cmp++; if (rgb !== 8'hE3) begin n_bad++; $display("FAIL pix_col0: got %h want E3", rgb); end
    tick();
    n_cmp++; if (rgb !== 8'h00) begin n_bad++; $display("FAIL pix_col1: got %h want 00", rgb); end
    drive(48, 18, 1, 1, 1);
    tick();
    drive(64, 18, 1, 1, 1);
    tick();
    tick();
    n_cmp++; if (rgb !== 8'h00) begin n_bad++; $display("FAIL pal0_invisible: got %h want 00", rgb); end
    tick();
    n_cmp++; if (rgb !== 8'hFF) begin n_bad++; $display("FAIL pal7_white: got %h want FF", rgb); end
    $display("test_pixel done, %0d compared", n_cmp);
  endtask

  task automatic test_back_to_back();
    logic [15:0] row_bits;
    logic [7:0]  want;
    row_bits = 16'b1010_0101_1100_0011;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(32 + i, 34, 1, 1, 1);
      else        drive(700, 34, 1, 1, 1);
      tick();
      if (i >= 2) begin
        want = row_bits[15 - (i - 2)] ? 8'hE0 : 8'h00;
        n_cmp++; if (rgb !== want) begin n_bad++; $display("FAIL b2b_col%0d: got %h want %h", i - 2, rgb, want); end
      end
    end
    $display("test_back_to_back done, %0d compared", n_cmp);
  endtask

  task automatic test_blank();
    logic [7:0] bp, hp, vp;
    drive(32, 18, 0, 1, 1);
    tick();
    n_cmp++; if (tile_addr !== 11'd0) begin n_bad++; $display("FAIL blank_bright_addr: got %0d want 0", tile_addr); end
    drive(700, 18, 1, 1, 1);
    tick();
    n_cmp++; if (tile_addr !== 11'd0) begin n_bad++; $display("FAIL blank_h700_addr: got %0d want 0", tile_addr); end
    drive(32, 480, 1, 1, 1);
    tick();
    n_cmp++; if (tile_addr !== 11'd0) begin n_bad++; $display("FAIL blank_v480_addr: got %0d want 0", tile_addr); end
    n_cmp++; if (rgb !== 8'h00) begin n_bad++; $display("FAIL blank_bright_rgb: got %h want 00", rgb); end
    tick();
    n_cmp++; if (rgb !== 8'h00) begin n_bad++; $display("FAIL blank_h700_rgb: got %h want 00", rgb); end
    tick();
    n_cmp++; if (rgb !== 8'h00) begin n_bad++; $display("FAIL blank_v480_rgb: got %h want 00", rgb); end
    bp = 8'b1011_0010;
    hp = 8'b0110_1100;
    vp = 8'b1101_0110;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(700, 18, bp[i], hp[i], vp[i]);
      else       drive(700, 18, 1, 1, 1);
      tick();
      if (i >= 2) begin
        n_cmp++; if ({bright, hSync, vSync} !== {bp[i - 2], hp[i - 2], vp[i - 2]}) begin
          n_bad++; $display("FAIL sync_delay_%0d: got %b%b%b want %b%b%b", i - 2, bright, hSync, vSync, bp[i - 2], hp[i - 2], vp[i - 2]); end
      end
    end
    $display("test_blank done, %0d compared", n_cmp);
  endtask

  task automatic test_frame_lines();
    logic [7:0] exp_q[$];
    logic [7:0] want;
    int lines[5] = '{14, 15, 16, 479, 480};
    int k = 0;
    int fails_here = 0;
    for (int i = 0; i < 1200; i++) tile_mem[i] = 8'($urandom);
    for (int i = 0; i < 512; i++)  glyph_rom[i] = 16'($urandom);
    for (int l = 0; l < 5; l++) begin
      for (int h = 0; h < 800; h++) begin
        drive(h, lines[l], (h < 640 && lines[l] < 480), (h < 656 || h >= 752), 1);
        exp_q.push_back(ref_rgb(h, lines[l], (h < 640 && lines[l] < 480)));
        tick();
        if (k >= 2) begin
          want = exp_q.pop_front();
          n_cmp++;
          if (rgb !== want) begin
            n_bad++;
            fails_here++;
            if (fails_here <= 10) $display("FAIL frame_pixel_%0d: got %h want %h", k - 2, rgb, want);
          end
        end
        k++;
      end
    end
    $display("test_frame_lines done, %0d compared", n_cmp);
  endtask

`ifdef CURSOR_OVERLAY_EN
  task automatic test_cursor();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cursor_col = 6'd2;
    cursor_row = 5'd3;
    cursor_on  = 1'b1;
    tile_mem[122]  = 8'hA5;
    tile_mem[123]  = 8'hA5;
    glyph_rom[80]  = 16'h8000;
    drive(32, 48, 1, 1, 1);
    tick(); tick(); tick();
    n_cmp++; if (rgb !== 8'hE3) begin n_bad++; $display("FAIL cursor_blink_off: got %h want E3", rgb); end
    for (int f = 0; f < 32; f++) begin
      drive(700, 500, 0, 1, 0); tick();
      drive(700, 500, 0, 1, 1); tick();
    end
    drive(32, 48, 1, 1, 1);
    tick(); tick(); tick();
    n_cmp++; if (rgb !== 8'h1C) begin n_bad++; $display("FAIL cursor_blink_on: got %h want 1C", rgb); end
    drive(48, 48, 1, 1, 1);
    tick(); tick(); tick();
    n_cmp++; if (rgb !== 8'hE3) begin n_bad++; $display("FAIL cursor_other_tile: got %h want E3", rgb); end
    for (int f = 0; f < 32; f++) begin
      drive(700, 500, 0, 1, 0); tick();
      drive(700, 500, 0, 1, 1); tick();
    end
    drive(32, 48, 1, 1, 1);
    tick(); tick(); tick();
    n_cmp++; if (rgb !== 8'hE3) begin n_bad++; $display("FAIL cursor_after_32: got %h want E3", rgb); end
    $display("test_cursor done, %0d compared", n_cmp);
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 1, 1);
`ifdef CURSOR_OVERLAY_EN
    cursor_col = 6'd0;
    cursor_row = 5'd0;
    cursor_on  = 1'b0;
`endif
    for (int i = 0; i < 1200; i++) tile_mem[i] = 8'h00;
    for (int i = 0; i < 512; i++)  glyph_rom[i] = 16'h0000;
    tile_mem[42]  = 8'hA5;
    tile_mem[43]  = 8'h05;
    tile_mem[44]  = 8'hE5;
    tile_mem[82]  = 8'h83;
    glyph_rom[82] = 16'h8000;
    glyph_rom[50] = 16'hA5C3;

    test_reset();
    test_addressing();
    test_pixel();
    test_back_to_back();
    test_blank();
    test_frame_lines();
`ifdef CURSOR_OVERLAY_EN
    test_cursor();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
